// File: rtl/game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : game_ctrl
// Purpose  : 2048 game controller: key handling, board register, tile spawn,
//            win/lose evaluation. Define SPAWN_FOUR_EN to allow 4'd2 spawns.
// Revision : 1.0  initial release
// ============================================================================
module game_ctrl #(
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter logic [3:0]  WIN_TILE  = 4'd11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_up,
    input  logic        key_down,
    input  logic        key_left,
    input  logic        key_right,
    input  logic        new_game,
    input  logic        load_en,
    input  logic [63:0] load_val,
    output logic [63:0] move_in,
    output logic        move_en,
    output logic        move_up,
    output logic        move_down,
    output logic        move_left,
    output logic        move_right,
    input  logic [63:0] move_out,
    output logic [63:0] board,
    output logic        busy,
    output logic        win,
    output logic        lose,
    output logic [15:0] moves
);

    typedef enum logic [2:0] {
        INIT0 = 3'd0,
        INIT1 = 3'd1,
        WAIT  = 3'd2,
        MOVE  = 3'd3,
        SPAWN = 3'd4,
        EVAL  = 3'd5,
        OVER  = 3'd6
    } state_t;

    localparam logic [3:0] c_SCAN_LAST = 4'd15;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [63:0] r_board;
    logic [15:0] r_moves;
    logic        r_win;
    logic        r_lose;
    logic [15:0] r_lfsr;
    logic [3:0]  r_key_prev;
    logic        r_ng_prev;
    logic [3:0]  r_dir;
    logic [3:0]  r_scan_cnt;
    logic [3:0]  r_scan_idx;

    logic [15:0] w_lfsr_nxt;
    logic [3:0]  w_keys;
    logic [3:0]  w_edge;
    logic [3:0]  w_dir_sel;
    logic        w_ng_edge;
    logic        w_in_spawn;
    logic [3:0]  w_scan_idx;
    logic [5:0]  w_scan_shift;
    logic [3:0]  w_scan_cell;
    logic        w_scan_hit;
    logic        w_scan_done;
    logic [3:0]  w_spawn_val;
    logic [3:0]  w_cells [16];
    logic        w_win;
    logic        w_lose;

    // Fibonacci form, taps 16,14,13,11, shifting toward bit 0
    assign w_lfsr_nxt = {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};

    assign w_keys    = {key_down, key_up, key_left, key_right};
    assign w_edge    = w_keys & ~r_key_prev;
    assign w_ng_edge = new_game & ~r_ng_prev;

    always_comb begin
        w_dir_sel = 4'b0000;
        if (w_edge[3])      w_dir_sel = 4'b1000;
        else if (w_edge[2]) w_dir_sel = 4'b0100;
        else if (w_edge[1]) w_dir_sel = 4'b0010;
        else if (w_edge[0]) w_dir_sel = 4'b0001;
    end

    // The first scan cycle takes its start cell from the LFSR; later cycles walk on
    assign w_in_spawn   = (r_state == INIT0) || (r_state == INIT1) || (r_state == SPAWN);
    assign w_scan_idx   = (r_scan_cnt == 4'd0) ? r_lfsr[3:0] : r_scan_idx;
    assign w_scan_shift = 6'd60 - {w_scan_idx, 2'b00};
    assign w_scan_cell  = r_board[w_scan_shift +: 4];
    assign w_scan_hit   = (w_scan_cell == 4'd0);
    assign w_scan_done  = w_scan_hit || (r_scan_cnt == c_SCAN_LAST);

`ifdef SPAWN_FOUR_EN
    assign w_spawn_val = (r_lfsr[6:4] == 3'b000) ? 4'd2 : 4'd1;
`else
    assign w_spawn_val = 4'd1;
`endif

    always_comb begin
        w_win  = 1'b0;
        w_lose = 1'b1;
        for (int i = 0; i < 16; i++) begin
            w_cells[i] = r_board[(15 - i) * 4 +: 4];
        end
        for (int i = 0; i < 16; i++) begin
            if (w_cells[i] >= WIN_TILE) w_win = 1'b1;
            if (w_cells[i] == 4'd0) w_lose = 1'b0;
            if (((i % 4) != 3) && (w_cells[i] == w_cells[i + 1])) w_lose = 1'b0;
            if ((i < 12) && (w_cells[i] == w_cells[i + 4])) w_lose = 1'b0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b1;
        move_en     = 1'b0;
        move_down   = 1'b0;
        move_up     = 1'b0;
        move_left   = 1'b0;
        move_right  = 1'b0;
        case (r_state)
            INIT0: if (w_scan_done) w_state_nxt = INIT1;
            INIT1: if (w_scan_done) w_state_nxt = EVAL;
            SPAWN: if (w_scan_done) w_state_nxt = EVAL;
            WAIT: begin
                busy = 1'b0;
                if (load_en)              w_state_nxt = EVAL;
                else if (w_edge != 4'd0)  w_state_nxt = MOVE;
            end
            MOVE: begin
                move_en    = 1'b1;
                move_down  = r_dir[3];
                move_up    = r_dir[2];
                move_left  = r_dir[1];
                move_right = r_dir[0];
                w_state_nxt = (move_out != r_board) ? SPAWN : WAIT;
            end
            EVAL: w_state_nxt = (w_win || w_lose) ? OVER : WAIT;
            OVER: begin
                busy = 1'b0;
                if (w_ng_edge) w_state_nxt = INIT0;
            end
            default: w_state_nxt = INIT0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= INIT0;
            r_board    <= 64'd0;
            r_moves    <= 16'd0;
            r_win      <= 1'b0;
            r_lose     <= 1'b0;
            r_lfsr     <= LFSR_SEED;
            r_key_prev <= 4'd0;
            r_ng_prev  <= 1'b0;
            r_dir      <= 4'd0;
            r_scan_cnt <= 4'd0;
            r_scan_idx <= 4'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_lfsr     <= w_lfsr_nxt;
            r_key_prev <= w_keys;
            r_ng_prev  <= new_game;
            if (w_in_spawn) begin
                if (w_scan_done) begin
                    r_scan_cnt <= 4'd0;
                    if (w_scan_hit) r_board[w_scan_shift +: 4] <= w_spawn_val;
                end else begin
                    r_scan_cnt <= r_scan_cnt + 4'd1;
                    r_scan_idx <= w_scan_idx + 4'd1;
                end
            end
            case (r_state)
                WAIT: begin
                    if (load_en)             r_board <= load_val;
                    else if (w_edge != 4'd0) r_dir   <= w_dir_sel;
                end
                MOVE: begin
                    r_board <= move_out;
                    if ((move_out != r_board) && (r_moves != 16'hFFFF))
                        r_moves <= r_moves + 16'd1;
                end
                EVAL: begin
                    r_win  <= w_win;
                    r_lose <= w_lose;
                end
                OVER: begin
                    if (w_ng_edge) begin
                        r_board <= 64'd0;
                        r_moves <= 16'd0;
                        r_win   <= 1'b0;
                        r_lose  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign move_in = r_board;
    assign board   = r_board;
    assign moves   = r_moves;
    assign win     = r_win;
    assign lose    = r_lose;

endmodule
`default_nettype wire

// File: tb/tb_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_game_ctrl
// Purpose  : Directed self-checking bench for game_ctrl with a behavioural
//            2048 slide/merge datapath.
// Revision : 1.0  initial release
// ============================================================================
module tb_game_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_up = 1'b0, key_down = 1'b0, key_left = 1'b0, key_right = 1'b0;
    logic        new_game = 1'b0;
    logic        load_en = 1'b0;
    logic [63:0] load_val = 64'd0;
    logic [63:0] move_in, move_out, board;
    logic        move_en, move_up, move_down, move_left, move_right;
    logic        busy, win, lose;
    logic [15:0] moves;

    int n_checks = 0;
    int n_fail   = 0;

    game_ctrl #(.LFSR_SEED(16'hACE1), .WIN_TILE(4'd11)) dut (
        .clk(clk), .rst(rst),
        .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
        .new_game(new_game), .load_en(load_en), .load_val(load_val),
        .move_in(move_in), .move_en(move_en), .move_up(move_up), .move_down(move_down),
        .move_left(move_left), .move_right(move_right), .move_out(move_out),
        .board(board), .busy(busy), .win(win), .lose(lose), .moves(moves)
    );

    always #5 clk = ~clk;

    // Slide and merge toward the commanded edge; identity when no command
    function automatic logic [63:0] dp_move(input logic [63:0] b, input logic [3:0] dir);
        logic [63:0] r;
        logic [3:0]  v [4];
        logic [3:0]  o [4];
        int          idx [4];
        int          n, k, m;
        r = b;
        if (dir == 4'd0) return b;
        for (int ln = 0; ln < 4; ln++) begin
            n = 0;
            for (int j = 0; j < 4; j++) begin
                if (dir[1])      idx[j] = ln * 4 + j;
                else if (dir[0]) idx[j] = ln * 4 + 3 - j;
                else if (dir[2]) idx[j] = j * 4 + ln;
                else             idx[j] = (3 - j) * 4 + ln;
                o[j] = 4'd0;
                v[j] = 4'd0;
            end
            for (int j = 0; j < 4; j++) begin
                if (b[(15 - idx[j]) * 4 +: 4] != 4'd0) begin
                    v[n] = b[(15 - idx[j]) * 4 +: 4];
                    n++;
                end
            end
            k = 0;
            m = 0;
            while (k < n) begin
                if ((k + 1 < n) && (v[k] == v[k + 1])) begin
                    o[m] = v[k] + 4'd1;
                    k += 2;
                end else begin
                    o[m] = v[k];
                    k += 1;
                end
                m++;
            end
            for (int j = 0; j < 4; j++) r[(15 - idx[j]) * 4 +: 4] = o[j];
        end
        return r;
    endfunction

    always_comb move_out = dp_move(move_in, {move_down, move_up, move_left, move_right});

    function automatic int count_nz(input logic [63:0] b);
        int c = 0;
        for (int i = 0; i < 16; i++) if (b[i * 4 +: 4] != 4'd0) c++;
        return c;
    endfunction

    function automatic int count_val(input logic [63:0] b, input logic [3:0] v);
        int c = 0;
        for (int i = 0; i < 16; i++) if (b[i * 4 +: 4] == v) c++;
        return c;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int max_cyc, input string tag);
        int ok = 0;
        for (int i = 0; i < max_cyc; i++) begin
            tick();
            if (!busy) begin
                ok = 1;
                break;
            end
        end
        check(tag, 64'(ok), 64'd1);
    endtask

    task automatic load_board(input logic [63:0] v);
        load_val = v;
        load_en  = 1'b1;
        tick();
        load_en  = 1'b0;
    endtask

    initial begin
        // Reset and initial two-tile deal
        tick(); tick(); tick();
        check("rst_board", board, 64'd0);
        check("rst_moves", 64'(moves), 64'd0);
        check("rst_busy", 64'(busy), 64'd1);
        check("rst_flags", {62'd0, win, lose}, 64'd0);
        check("rst_move_cmd", {59'd0, move_en, move_up, move_down, move_left, move_right}, 64'd0);
        rst = 1'b0;
        wait_idle(36, "init_idle");
        check("init_nz", 64'(count_nz(board)), 64'd2);
        check("init_ones", 64'(count_val(board, 4'd1)), 64'd2);
        check("init_moves", 64'(moves), 64'd0);

        // Load, then a merging move right
        load_board(64'h1100_0000_0000_0000);
        check("load_eval_busy", 64'(busy), 64'd1);
        tick();
        check("load_wait_busy", 64'(busy), 64'd0);
        check("load_board", board, 64'h1100_0000_0000_0000);
        key_right = 1'b1;
        tick();
        key_right = 1'b0;
        check("right_cmd", {59'd0, move_en, move_up, move_down, move_left, move_right}, 64'b10001);
        check("right_move_in", move_in, 64'h1100_0000_0000_0000);
        tick();
        check("right_board", board, 64'h0002_0000_0000_0000);
        check("right_moves", 64'(moves), 64'd1);
        wait_idle(20, "right_idle");
        check("right_spawn_nz", 64'(count_nz(board)), 64'd2);
        check("right_spawn_one", 64'(count_val(board, 4'd1)), 64'd1);
        check("right_keep_two", 64'(board[51:48]), 64'd2);

        // A move down that changes nothing
        load_board(64'h0000_0000_0000_1234);
        tick();
        key_down = 1'b1;
        tick();
        check("down_cmd", {59'd0, move_en, move_up, move_down, move_left, move_right}, 64'b10100);
        tick();
        check("noop_busy", 64'(busy), 64'd0);
        check("noop_board", board, 64'h0000_0000_0000_1234);
        check("noop_moves", 64'(moves), 64'd1);
        tick();
        check("noop_hold_busy", 64'(busy), 64'd0);
        check("noop_hold_board", board, 64'h0000_0000_0000_1234);
        key_down = 1'b0;

        // Lose, keys ignored in OVER, then new game
        load_board(64'h1212_2121_1212_2121);
        check("lose_eval_lose", 64'(lose), 64'd0);
        tick();
        check("lose_flag", {62'd0, win, lose}, 64'd1);
        check("lose_over_busy", 64'(busy), 64'd0);
        key_left = 1'b1;
        tick();
        check("over_no_cmd", 64'(move_en), 64'd0);
        tick();
        key_left = 1'b0;
        check("over_board", board, 64'h1212_2121_1212_2121);
        check("over_busy", 64'(busy), 64'd0);
        new_game = 1'b1;
        tick();
        check("ng_board", board, 64'd0);
        check("ng_moves", 64'(moves), 64'd0);
        check("ng_flags", {62'd0, win, lose}, 64'd0);
        check("ng_busy", 64'(busy), 64'd1);
        wait_idle(36, "ng_idle");
        new_game = 1'b0;
        check("ng_nz", 64'(count_nz(board)), 64'd2);

        // Win, then key priority on a fresh game
        load_board(64'hB000_0000_0000_0000);
        tick();
        check("win_flag", {62'd0, win, lose}, 64'd2);
        check("win_busy", 64'(busy), 64'd0);
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        check("win_ng_flag", 64'(win), 64'd0);
        wait_idle(36, "win_ng_idle");
        load_board(64'h1000_0000_0000_0000);
        tick();
        check("prio_wait", 64'(busy), 64'd0);
        key_up   = 1'b1;
        key_down = 1'b1;
        tick();
        key_up   = 1'b0;
        key_down = 1'b0;
        check("prio_cmd", {59'd0, move_en, move_up, move_down, move_left, move_right}, 64'b10100);
        tick();
        check("prio_board", board, 64'h0000_0000_0000_1000);
        check("prio_moves", 64'(moves), 64'd1);
        check("prio_spawn_busy", 64'(busy), 64'd1);

        // Reset in the middle of a spawn
        rst = 1'b1;
        tick();
        check("midrst_board", board, 64'd0);
        check("midrst_moves", 64'(moves), 64'd0);
        check("midrst_busy", 64'(busy), 64'd1);
        rst = 1'b0;
        wait_idle(36, "midrst_idle");
        check("midrst_nz", 64'(count_nz(board)), 64'd2);
        check("midrst_ones", 64'(count_val(board, 4'd1)), 64'd2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
